// File: rtl/regfile_bank.sv
// Purpose: 2^ADDR_WIDTH x DATA_WIDTH register file with a hardwired-zero top register and optional write bypass.
// Latency: reads are combinational; writes land on the rising edge and are visible after it (same cycle with BYPASS=1).
// Backpressure: none; every write is accepted, so there is no valid/ready handshake.
module regfile_bank #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    input  logic [ADDR_WIDTH-1:0] rd_addr2,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2
);

    localparam int NREG = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(NREG - 1);

    // Only NREG-1 real storage entries; the zero register has no flops.
    logic [DATA_WIDTH-1:0] store  [NREG-1];
    logic [DATA_WIDTH-1:0] mux_in [NREG];
    logic [NREG-2:0]       wr_sel;
    logic                  wr_live;
    logic                  byp1;
    logic                  byp2;

    assign wr_live = wr_en && !reset;

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NREG - 1; i++) begin
            wr_sel[i] = wr_live && (wr_addr == ADDR_WIDTH'(i));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG - 1; i++) begin
            if (reset) begin
                store[i] <= '0;
            end else if (wr_sel[i]) begin
                store[i] <= wr_data;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NREG - 1; g++) begin : g_mux_in
            assign mux_in[g] = store[g];
        end
    endgenerate
    assign mux_in[NREG-1] = '0;

    // Forwarding never targets the zero register, so it cannot mask the hardwired 0.
    assign byp1 = (BYPASS != 0) && wr_live && (wr_addr == rd_addr1) && (rd_addr1 != ZERO_IDX);
    assign byp2 = (BYPASS != 0) && wr_live && (wr_addr == rd_addr2) && (rd_addr2 != ZERO_IDX);

    always_comb begin
        rd_data1 = mux_in[rd_addr1];
        if (byp1) begin
            rd_data1 = wr_data;
        end
    end

    always_comb begin
        rd_data2 = mux_in[rd_addr2];
        if (byp2) begin
            rd_data2 = wr_data;
        end
    end

endmodule

// File: tb/tb_regfile_bank.sv
// Bench for regfile_bank: BYPASS=0 and BYPASS=1 instances share stimulus and are checked
// every cycle against an array model, plus directed literal expectations.
module tb_regfile_bank;

    localparam int DW   = 64;
    localparam int AW   = 5;
    localparam int NREG = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] rd_addr1 = '0;
    logic [AW-1:0] rd_addr2 = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] rd0_1, rd0_2, rd1_1, rd1_2;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model [NREG];
    bit            model_ok = 1'b0;

    always #5 clk = ~clk;

    regfile_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(0)) dut0 (
        .clk(clk), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .rd_data1(rd0_1), .rd_data2(rd0_2)
    );

    regfile_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1)) dut1 (
        .clk(clk), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .rd_data1(rd1_1), .rd_data2(rd1_2)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] expect_rd(input logic [AW-1:0] a, input bit byp);
        if (int'(a) == NREG - 1) return '0;
        if (byp && wr_en && !reset && a == wr_addr) return wr_data;
        return model[a];
    endfunction

    // Model state update: reset clears all, otherwise a write to any non-zero-register address lands.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) model[i] = '0;
            model_ok = 1'b1;
        end else if (wr_en && int'(wr_addr) != NREG - 1) begin
            model[wr_addr] = wr_data;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("model_b0_p1", rd0_1, expect_rd(rd_addr1, 1'b0));
            chk("model_b0_p2", rd0_2, expect_rd(rd_addr2, 1'b0));
            chk("model_b1_p1", rd1_1, expect_rd(rd_addr1, 1'b1));
            chk("model_b1_p2", rd1_2, expect_rd(rd_addr2, 1'b1));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        wr_en = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] base;
        logic [DW-1:0] exp3;
        base = 64'h0123_4567_89AB_0000;

        // Reset then sweep
        cyc();
        reset = 1'b0;
        for (int a = 0; a < NREG; a++) begin
            rd_addr1 = AW'(a);
            rd_addr2 = AW'(a);
            @(negedge clk);
            chk("reset_sweep_b0", rd0_1 | rd0_2, 64'h0);
            chk("reset_sweep_b1", rd1_1 | rd1_2, 64'h0);
            cyc();
        end

        // Write/readback
        for (int i = 0; i < NREG - 1; i++) wr(i, base + DW'(i));
        for (int i = 0; i < NREG - 1; i++) begin
            rd_addr1 = AW'(i);
            rd_addr2 = AW'(30 - i);
            @(negedge clk);
            chk("readback_p1", rd0_1, base + DW'(i));
            chk("readback_p2", rd0_2, base + DW'(30 - i));
            chk("readback_b1_p1", rd1_1, base + DW'(i));
            cyc();
        end

        // Zero register, write held active
        wr_en = 1'b1;
        wr_addr = 5'd31;
        wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        rd_addr1 = 5'd31;
        @(negedge clk);
        chk("zero_byp_held", rd1_1, 64'h0);
        cyc();
        @(negedge clk);
        chk("zero_after_b0", rd0_1, 64'h0);
        chk("zero_after_b1", rd1_1, 64'h0);
        cyc();
        wr_en = 1'b0;

        // Read during write
        wr(5, 64'h11);
        wr_en = 1'b1;
        wr_addr = 5'd5;
        wr_data = 64'h22;
        rd_addr1 = 5'd5;
        @(negedge clk);
        chk("rdw_b0_before", rd0_1, 64'h11);
        chk("rdw_b1_before", rd1_1, 64'h22);
        cyc();
        wr_en = 1'b0;
        @(negedge clk);
        chk("rdw_b0_after", rd0_1, 64'h22);
        cyc();

        // Reset vs write collision
        wr(7, 64'hAA);
        reset = 1'b1;
        wr_en = 1'b1;
        wr_addr = 5'd7;
        wr_data = 64'hBB;
        rd_addr1 = 5'd7;
        @(negedge clk);
        chk("rst_coll_b0_during", rd0_1, 64'hAA);
        chk("rst_coll_b1_during", rd1_1, 64'hAA);
        cyc();
        reset = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        chk("rst_coll_b0_after", rd0_1, 64'h0);
        chk("rst_coll_b1_after", rd1_1, 64'h0);
        cyc();

        // Write enable low holds state
        wr(3, 64'h33);
        wr(9, 64'h99);
        wr_en = 1'b0;
        wr_addr = 5'd3;
        wr_data = 64'h5A;
        repeat (4) cyc();
        for (int a = 0; a < NREG; a++) begin
            exp3 = (a == 3) ? 64'h33 : (a == 9) ? 64'h99 : 64'h0;
            rd_addr1 = AW'(a);
            rd_addr2 = AW'(NREG - 1 - a);
            @(negedge clk);
            chk("wren_low_p1_b0", rd0_1, exp3);
            chk("wren_low_p1_b1", rd1_1, exp3);
            cyc();
        end

        // Write on the same edge reset is first sampled low
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        wr(4, 64'h44);
        rd_addr1 = 5'd4;
        @(negedge clk);
        chk("post_reset_write", rd0_1, 64'h44);
        cyc();

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            reset    = ($urandom_range(0, 31) == 0);
            wr_en    = $urandom_range(0, 1) == 1;
            wr_addr  = ($urandom_range(0, 7) == 0) ? 5'd31 : AW'($urandom_range(0, NREG - 1));
            wr_data  = {$urandom, $urandom};
            rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NREG - 1));
            rd_addr2 = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NREG - 1));
            cyc();
        end
        reset = 1'b0;
        wr_en = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
